// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the digit-serial adder controller: FSM encoding and digit width.
package adder_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/adder_bk_4b.sv
// 4-bit Brent-Kung adder slice: PG generation, prefix carry tree, sum XOR.
module adder_bk_4b
  import adder_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32, g30, p30;
  logic       c1, c2;

  assign g = a & b;
  assign p = a ^ b;

  // Up-sweep: pairwise group terms, then the full 4-bit group
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;

  // Down-sweep fills in the odd-position carry left over by the tree
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g10 | (p10 & cin);
  assign c3   = g[2] | (p[2] & c2);
  assign cout = g30 | (p30 & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial add/subtract: one 4-bit BK slice reused over WIDTH/4 cycles, valid/ready on both sides.
module digit_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("digit_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               accept;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] s_dig;
  logic               c_out;
  logic               c3;

  always_comb begin
    ready_o = 1'b0;
    unique case (state)
      ST_IDLE: ready_o = 1'b1;
      ST_DONE: ready_o = ready_i;
      default: ready_o = 1'b0;
    endcase
  end

  assign accept  = valid_i & ready_o;
  assign valid_o = (state == ST_DONE);
  assign busy_o  = (state == ST_RUN);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;

  // Operands are only sampled at accept, so they need no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q <= a_i;
      b_q <= sub_i ? ~b_i : b_i;
    end
  end

  assign a_dig = a_q[int'(idx)*DIGIT_W +: DIGIT_W];
  assign b_dig = b_q[int'(idx)*DIGIT_W +: DIGIT_W];

  adder_bk_4b u_slice (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .sum  (s_dig),
    .cout (c_out),
    .c3   (c3)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1, so the +1 rides in on the initial carry
      state <= ST_RUN;
      idx   <= '0;
      carry <= sub_i ? 1'b1 : cin_i;
    end else begin
      unique case (state)
        ST_RUN: begin
          sum_q[int'(idx)*DIGIT_W +: DIGIT_W] <= s_dig;
          carry <= c_out;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state  <= ST_DONE;
            cout_q <= c_out;
            ovf_q  <= c3 ^ c_out;
          end
        end
        ST_DONE: begin
          if (ready_i) state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/digit_serial_adder_ctrl.md
DIGIT_SERIAL_ADDER_CTRL -- requirements
Module: digit_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; WIDTH SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1, request valid.
REQ-005 SHALL have port ready_o, output, 1, block can accept a request.
REQ-006 SHALL have port a_i, input, WIDTH, operand A.
REQ-007 SHALL have port b_i, input, WIDTH, operand B.
REQ-008 SHALL have port cin_i, input, 1, carry-in, used only when sub_i=0.
REQ-009 SHALL have port sub_i, input, 1, 1 = compute A-B.
REQ-010 SHALL have port valid_o, output, 1, result valid.
REQ-011 SHALL have port ready_i, input, 1, consumer accepts the result.
REQ-012 SHALL have port sum_o, output, WIDTH, result.
REQ-013 SHALL have port cout_o, output, 1, carry out of the MSB.
REQ-014 SHALL have port ovf_o, output, 1, two's-complement overflow.
REQ-015 SHALL have port busy_o, output, 1, high in RUN.

Function
REQ-016 SHALL use an FSM with states IDLE, RUN and DONE, and SHALL process 4 bits (one digit) per RUN cycle through one 4-bit Brent-Kung slice.
REQ-017 SHALL drive ready_o=1 in IDLE, ready_o=ready_i in DONE, and ready_o=0 in RUN.
REQ-018 SHALL, on valid_i&ready_o, capture a_i and the effective B (b_i inverted if sub_i), set digit index 0, set the carry register to (sub_i ? 1 : cin_i), and enter RUN.
REQ-019 SHALL require operands stable only in the accept cycle.
REQ-020 SHALL, in RUN at each edge, write the slice sum to result digit idx, load the slice carry-out into the carry register, and increment idx.
REQ-021 SHALL go RUN->DONE at the edge that processes digit WIDTH/4-1.
REQ-022 SHALL assert valid_o exactly WIDTH/4 edges after the accept edge.
REQ-023 SHALL set cout_o to the carry out of bit WIDTH-1.
REQ-024 SHALL set ovf_o = carry into bit WIDTH-1 XOR cout_o, captured from the final digit's internal bit-3 carry.
REQ-025 SHALL assert valid_o only in DONE, and SHALL hold sum_o, cout_o and ovf_o stable while valid_o&!ready_i.
REQ-026 SHALL, in DONE with ready_i=1, go to IDLE, or directly to RUN if valid_i=1 in the same cycle (back-to-back accept, no bubble).
REQ-027 SHALL produce results modulo 2^WIDTH, with no saturation.
REQ-028 SHALL hold busy_o=1 exactly in RUN.

Reset
REQ-029 SHALL, when rst_ni=0 at any time including mid-RUN, immediately force state IDLE, idx=0, carry=0, and sum_o, cout_o, ovf_o, valid_o, busy_o=0.
REQ-030 SHALL drive ready_o=1 while in reset, since the state is IDLE.
REQ-031 SHALL discard an in-flight operation on reset, producing no valid_o for it.
REQ-032 SHALL accept a new request in the first cycle after rst_ni deasserts.

Structure
REQ-033 SHALL define the FSM state enum and the constant DIGIT_W=4 in shared package adder_ctrl_pkg.
REQ-034 SHALL instantiate one sub-module adder_bk_4b: PG generation, 4-bit BK carry tree, and sum XOR; its outputs SHALL be sum[3:0], cout and carry-into-bit-3.
REQ-035 SHALL add no combinational path from valid_i or a_i/b_i to sum_o.

Verification (WIDTH=32)
REQ-036 SHALL cover: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> sum_o=0x00000000, cout_o=1, ovf_o=0, valid_o exactly 8 edges after accept.
REQ-037 SHALL cover: A=0x7FFFFFFF, B=1, sub=0 -> sum_o=0x80000000, cout_o=0, ovf_o=1.
REQ-038 SHALL cover: A=5, B=7, sub=1, cin=0 -> sum_o=0xFFFFFFFE, cout_o=0, ovf_o=0; A=7, B=5, sub=1 -> sum_o=2, cout_o=1.
REQ-039 SHALL cover: ready_i held 0 for 10 cycles after valid_o -> outputs unchanged, ready_o=0, no second accept.
REQ-040 SHALL cover: rst_ni low at 3rd RUN cycle -> all outputs 0 asynchronously; next request 0x12345678+0x11111111 -> 0x23456789, cout_o=0.
REQ-041 SHALL cover: valid_i=1 and ready_i=1 in DONE -> new op accepted same cycle, next valid_o 8 edges later, busy_o never drops in between.
